// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for a single-port data memory.
// Optional macro DMEM_ARB_RR_EN selects round-robin tie-breaking (default: port 0 fixed priority).
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_we,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [DATA_W-1:0] p0_req_wdata,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rsp_rdata,
  output logic              p0_rsp_err,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_we,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_wdata,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rsp_rdata,
  output logic              p1_rsp_err,
  output logic              mem_write,
  output logic              mem_read,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_RESP = 2'd2} state_t;

  // Handshake: a request transfers on a rising clk edge where req_valid && req_ready.
  // Requesters hold valid/we/addr/wdata stable until that edge. rsp_valid is a one-cycle pulse.

  state_t             state, state_nx;
  logic               gnt0, gnt1, can_accept, accept;
  logic               port_q, we_q, err_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [ADDR_W-1:0]  sel_addr;
  logic               sel_we, sel_err;
  logic [DATA_W-1:0]  sel_wdata;
  logic [DATA_W-1:0]  rsp_data;

`ifdef DMEM_ARB_RR_EN
  logic last_p1;

  // On a tie the port that was not granted most recently wins.
  always_comb begin
    gnt0 = p0_req_valid;
    gnt1 = p1_req_valid;
    if (p0_req_valid && p1_req_valid) begin
      gnt0 = last_p1;
      gnt1 = !last_p1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_p1 <= 1'b1;
    else if (accept) last_p1 <= gnt1;
  end
`else
  always_comb begin
    gnt0 = p0_req_valid;
    gnt1 = p1_req_valid && !p0_req_valid;
  end
`endif

  assign can_accept   = (state == S_IDLE) || (state == S_RESP);
  assign p0_req_ready = can_accept && gnt0;
  assign p1_req_ready = can_accept && gnt1;
  assign accept       = p0_req_ready || p1_req_ready;

  assign sel_addr  = gnt1 ? p1_req_addr  : p0_req_addr;
  assign sel_we    = gnt1 ? p1_req_we    : p0_req_we;
  assign sel_wdata = gnt1 ? p1_req_wdata : p0_req_wdata;
  assign sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr >= ADDR_W'(4 * DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        port_q  <= gnt1;
        we_q    <= sel_we;
        err_q   <= sel_err;
        idx_q   <= sel_addr[IDX_W+1:2];
        wdata_q <= sel_wdata;
      end
    end
  end

  // Address/data registers only change on accept, so they hold between accesses.
  assign mem_addr  = {{(32-IDX_W){1'b0}}, idx_q};
  assign mem_wdata = wdata_q;
  assign dbg_state = state;

  always_comb begin
    state_nx     = state;
    mem_write    = 1'b0;
    mem_read     = 1'b0;
    p0_rsp_valid = 1'b0;
    p1_rsp_valid = 1'b0;
    rsp_data     = '0;
    case (state)
      S_IDLE:  if (accept) state_nx = S_ISSUE;
      S_ISSUE: begin
        state_nx  = S_RESP;
        mem_write = !err_q && we_q;
        mem_read  = !err_q && !we_q;
      end
      S_RESP: begin
        state_nx     = accept ? S_ISSUE : S_IDLE;
        p0_rsp_valid = !port_q;
        p1_rsp_valid = port_q;
        if (!we_q && !err_q) rsp_data = mem_rdata;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign p0_rsp_rdata = p0_rsp_valid ? rsp_data : '0;
  assign p1_rsp_rdata = p1_rsp_valid ? rsp_data : '0;
  assign p0_rsp_err   = p0_rsp_valid && err_q;
  assign p1_rsp_err   = p1_rsp_valid && err_q;

endmodule
